seg7_capture: RTL and testbench

- Receive side of the multiplexed 7-segment display interface. It watches the one-hot digit strobes and the segment lines of a 3-digit scanned display, and waits for each digit dwell to settle.
- Each settled glyph is decoded back to a hex nibble. A complete 3-digit frame is published as one word.
- Used to loop back our own display driver for self-test, and to read external scanned displays.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_to_hex.sv | 21 ++
 rtl/seg7_capture.sv | 118 +++++++++++
 tb/tb_seg7_capture.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, glyph table and decode payload for the 7-segment capture slice.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_GLYPHS = 16;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Segment pattern {G,F,E,D,C,B,A} per hex nibble
  localparam logic [SEG_W-1:0] GLYPH [NUM_GLYPHS] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [NIB_W-1:0] nibble;
    logic             blank;
    logic             err;
  } dig_dec_t;

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse glyph lookup: segment pattern to {nibble, blank, err}.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output dig_dec_t         dec
);

  always_comb begin
    dec.nibble = '0;
    dec.blank  = (seg == SEG_BLANK);
    dec.err    = (seg != SEG_BLANK);
    for (int unsigned i = 0; i < NUM_GLYPHS; i++) begin
      if (seg == GLYPH[4'(i)]) begin
        dec.nibble = NIB_W'(i);
        dec.err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures settled digit dwells of a scanned 3-digit display and publishes whole frames.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DIGITS-1:0]       dig_sel,
  input  logic [SEG_W-1:0]            seg,
  input  logic                        clr_err,
  output logic [NUM_DIGITS*NIB_W-1:0] digits,
  output logic [NUM_DIGITS-1:0]       blank,
  output logic [NUM_DIGITS-1:0]       seg_err,
  output logic                        frame_valid,
  output logic                        sel_fault
);

  logic [NUM_DIGITS-1:0]       sel_m, sel_s;
  logic [SEG_W-1:0]            seg_m, seg_s;
  logic [CNT_W-1:0]            cnt;
  logic                        captured;
  logic [NUM_DIGITS-1:0]       seen;
  dig_dec_t                    shadow [NUM_DIGITS];
  dig_dec_t                    dec;

  logic                        changed;
  logic                        capture;
  logic                        fault;
  logic [NUM_DIGITS-1:0]       cap_bits;
  logic [NUM_DIGITS*NIB_W-1:0] sh_nib;
  logic [NUM_DIGITS-1:0]       sh_blank, sh_err;

  // Two-flop synchronisers on the strobe and segment lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_m <= '0;
      sel_s <= '0;
      seg_m <= '0;
      seg_s <= '0;
    end else begin
      sel_m <= dig_sel;
      sel_s <= sel_m;
      seg_m <= seg;
      seg_s <= seg_m;
    end
  end

  seg7_to_hex u_dec (
    .seg (seg_s),
    .dec (dec)
  );

  // Incoming sample differs from the held one: restart the dwell
  always_comb begin
    changed = ({sel_m, seg_m} != {sel_s, seg_s});
    capture = !changed && !captured && (cnt == CNT_W'(SETTLE_CYCLES - 1));
    fault   = capture && (sel_s != '0) && !is_onehot(sel_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      captured <= 1'b0;
    end else if (changed) begin
      cnt      <= '0;
      captured <= 1'b0;
    end else begin
      if (cnt != CNT_W'(SETTLE_CYCLES)) cnt <= cnt + CNT_W'(1);
      if (capture) captured <= 1'b1;
    end
  end

  // dig_sel bit NUM_DIGITS-1 strobes digit 0
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign cap_bits[k] = capture && is_onehot(sel_s) && sel_s[NUM_DIGITS-1-k];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shadow[k] <= '0;
      else if (cap_bits[k]) shadow[k] <= dec;
    end

    assign sh_nib[k*NIB_W +: NIB_W] = shadow[k].nibble;
    assign sh_blank[k]              = shadow[k].blank;
    assign sh_err[k]                = shadow[k].err;
  end

  // Frame publish one edge after every digit has been seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen        <= '0;
      digits      <= '0;
      blank       <= '0;
      seg_err     <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (seen == '1) begin
        digits      <= sh_nib;
        blank       <= sh_blank;
        seg_err     <= sh_err;
        frame_valid <= 1'b1;
        seen        <= cap_bits;
      end else begin
        seen        <= seen | cap_bits;
      end
    end
  end

  // Sticky strobe fault; a fault in the clearing cycle wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sel_fault <= 1'b0;
    else if (fault)   sel_fault <= 1'b1;
    else if (clr_err) sel_fault <= 1'b0;
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus randomized dwells vs a run-length model.
module tb_seg7_capture;

  localparam int unsigned SETTLE = 4;
  localparam logic [6:0] TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  dig_sel = '0;
  logic [6:0]  seg = '0;
  logic        clr_err = 1'b0;
  logic [11:0] digits;
  logic [2:0]  blank, seg_err;
  logic        frame_valid, sel_fault;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int fv_count = 0;
  int fv_edge = -1;

  // Reference model: run length of identical pin samples drives captures
  logic [9:0]  m_last;
  int          m_run;
  logic [3:0]  m_nib [3];
  logic [2:0]  m_sb, m_se, m_seen;
  logic [11:0] m_digits;
  logic [2:0]  m_blank, m_err;
  logic        m_fault;
  int          m_frames = 0;

  seg7_capture #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dig_sel     (dig_sel),
    .seg         (seg),
    .clr_err     (clr_err),
    .digits      (digits),
    .blank       (blank),
    .seg_err     (seg_err),
    .frame_valid (frame_valid),
    .sel_fault   (sel_fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      fv_count = fv_count + 1;
      fv_edge  = edge_cnt;
    end
  end

  task automatic model_reset();
    m_last = '0;
    m_run  = 2;
    for (int i = 0; i < 3; i++) m_nib[i] = '0;
    m_sb = '0; m_se = '0; m_seen = '0;
    m_digits = '0; m_blank = '0; m_err = '0;
    m_fault = 1'b0;
  endtask

  task automatic model_edge(input logic [9:0] p);
    logic [2:0] s;
    logic [6:0] g;
    logic [1:0] k;
    logic       f;
    int         ones;
    f = 1'b0;
    if (m_seen == 3'b111) begin
      m_digits = {m_nib[2], m_nib[1], m_nib[0]};
      m_blank  = m_sb;
      m_err    = m_se;
      m_frames = m_frames + 1;
      m_seen   = '0;
    end
    if (m_run == int'(SETTLE) + 1) begin
      s = m_last[9:7];
      g = m_last[6:0];
      ones = $countones(s);
      if (ones == 1) begin
        k = s[2] ? 2'd0 : (s[1] ? 2'd1 : 2'd2);
        m_nib[k] = 4'h0;
        m_sb[k]  = (g == 7'h00);
        m_se[k]  = (g != 7'h00);
        for (logic [4:0] i = 0; i < 16; i++) begin
          if (TBL[i[3:0]] == g) begin
            m_nib[k] = i[3:0];
            m_se[k]  = 1'b0;
          end
        end
        m_seen[k] = 1'b1;
      end else if (ones >= 2) begin
        f = 1'b1;
      end
    end
    if (f) m_fault = 1'b1;
    else if (clr_err) m_fault = 1'b0;
    if (p == m_last) begin
      if (m_run < 1000) m_run = m_run + 1;
    end else begin
      m_last = p;
      m_run  = 1;
    end
  endtask

  task automatic drive(input logic [2:0] s, input logic [6:0] g, input int n);
    for (int i = 0; i < n; i++) begin
      dig_sel = s;
      seg     = g;
      @(posedge clk);
      model_edge({s, g});
      edge_cnt = edge_cnt + 1;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic dwell(input logic [2:0] s, input logic [6:0] g);
    drive(s, g, 8);
    drive(3'b000, 7'h00, 2);
  endtask

  task automatic test_reset();
    int f0;
    rst_n = 1'b0; dig_sel = 3'b100; seg = 7'h7F;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL rst_digits got %h exp 000", digits); end
    checks++; if ({blank, seg_err} !== 6'b0) begin errors++; $display("FAIL rst_flags got %b exp 0", {blank, seg_err}); end
    checks++; if ({frame_valid, sel_fault} !== 2'b00) begin errors++; $display("FAIL rst_pulse got %b exp 00", {frame_valid, sel_fault}); end
    model_reset();
    rst_n = 1'b1;
    f0 = fv_count;
    drive(3'b100, 7'h7F, 20);
    checks++; if (digits !== 12'h000) begin errors++; $display("FAIL post_rst_digits got %h exp 000", digits); end
    checks++; if (fv_count - f0 !== 0) begin errors++; $display("FAIL post_rst_frames got %0d exp 0", fv_count - f0); end
  endtask

  task automatic test_static_scan();
    int f0;
    f0 = fv_count;
    for (int r = 0; r < 3; r++) begin
      dwell(3'b100, 7'h4F);
      dwell(3'b010, 7'h5B);
      dwell(3'b001, 7'h06);
    end
    checks++; if (digits !== 12'h123) begin errors++; $display("FAIL scan_digits got %h exp 123", digits); end
    checks++; if ({blank, seg_err} !== 6'b0) begin errors++; $display("FAIL scan_flags got %b exp 0", {blank, seg_err}); end
    checks++; if (fv_count - f0 !== 3) begin errors++; $display("FAIL scan_frames got %0d exp 3", fv_count - f0); end
    checks++; if (m_frames !== fv_count) begin errors++; $display("FAIL scan_model_frames got %0d exp %0d", fv_count, m_frames); end
  endtask

  task automatic test_settling();
    int f0, n0;
    dwell(3'b010, 7'h5B);
    dwell(3'b001, 7'h06);
    f0 = fv_count;
    drive(3'b100, 7'h7D, 2);
    drive(3'b100, 7'h00, 3);
    n0 = edge_cnt + 1;
    drive(3'b100, 7'h7D, 5);
    drive(3'b000, 7'h00, 6);
    checks++; if (digits !== 12'h126) begin errors++; $display("FAIL settle_digits got %h exp 126", digits); end
    checks++; if (blank !== 3'b000) begin errors++; $display("FAIL settle_blank got %b exp 000", blank); end
    checks++; if (fv_count - f0 !== 1) begin errors++; $display("FAIL settle_frames got %0d exp 1", fv_count - f0); end
    checks++; if (fv_edge !== n0 + int'(SETTLE) + 2) begin errors++; $display("FAIL settle_latency got %0d exp %0d", fv_edge - n0, SETTLE + 2); end
  endtask

  task automatic test_err_blank();
    dwell(3'b010, 7'h01);
    dwell(3'b001, 7'h00);
    dwell(3'b100, 7'h71);
    checks++; if (digits !== 12'h00F) begin errors++; $display("FAIL eb_digits got %h exp 00F", digits); end
    checks++; if (seg_err !== 3'b010) begin errors++; $display("FAIL eb_seg_err got %b exp 010", seg_err); end
    checks++; if (blank !== 3'b100) begin errors++; $display("FAIL eb_blank got %b exp 100", blank); end
  endtask

  task automatic test_sel_fault();
    int f0;
    f0 = fv_count;
    dwell(3'b100, 7'h4F);
    dwell(3'b110, 7'h3F);
    checks++; if (sel_fault !== 1'b1) begin errors++; $display("FAIL fault_set got %b exp 1", sel_fault); end
    checks++; if (fv_count - f0 !== 0) begin errors++; $display("FAIL fault_frames got %0d exp 0", fv_count - f0); end
    checks++; if (digits !== 12'h00F) begin errors++; $display("FAIL fault_hold got %h exp 00F", digits); end
    dwell(3'b010, 7'h5B);
    dwell(3'b001, 7'h06);
    checks++; if (digits !== 12'h123) begin errors++; $display("FAIL fault_shadow got %h exp 123", digits); end
    clr_err = 1'b1; drive(3'b000, 7'h00, 1); clr_err = 1'b0;
    checks++; if (sel_fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %b exp 0", sel_fault); end
    drive(3'b011, 7'h3F, int'(SETTLE) + 1);
    clr_err = 1'b1; drive(3'b000, 7'h00, 1); clr_err = 1'b0;
    drive(3'b000, 7'h00, 2);
    checks++; if (sel_fault !== 1'b1) begin errors++; $display("FAIL fault_vs_clear got %b exp 1", sel_fault); end
    checks++; if (sel_fault !== m_fault) begin errors++; $display("FAIL fault_model got %b exp %b", sel_fault, m_fault); end
  endtask

  task automatic test_reset_mid();
    int f0;
    dwell(3'b100, 7'h6F);
    dwell(3'b010, 7'h7F);
    dig_sel = '0; seg = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    #1;
    checks++; if ({digits, sel_fault} !== 13'h0) begin errors++; $display("FAIL mid_rst_state got %h exp 0", {digits, sel_fault}); end
    f0 = fv_count;
    dwell(3'b100, 7'h6F);
    dwell(3'b010, 7'h7F);
    dwell(3'b001, 7'h07);
    drive(3'b000, 7'h00, 4);
    checks++; if (fv_count - f0 !== 1) begin errors++; $display("FAIL mid_rst_frames got %0d exp 1", fv_count - f0); end
    checks++; if (digits !== 12'h789) begin errors++; $display("FAIL mid_rst_digits got %h exp 789", digits); end
  endtask

  task automatic test_random();
    logic [2:0] s;
    logic [6:0] g;
    int         pick;
    for (int d = 0; d < 300; d++) begin
      pick = int'($urandom_range(0, 19));
      s = (pick < 5) ? 3'b100 : (pick < 10) ? 3'b010 : (pick < 15) ? 3'b001 :
          (pick < 18) ? 3'b000 : (pick == 18) ? 3'b110 : 3'b011;
      pick = int'($urandom_range(0, 19));
      if (pick < 14) g = TBL[$urandom_range(0, 15)];
      else if (pick < 17) g = 7'h00;
      else g = 7'($urandom);
      clr_err = ($urandom_range(0, 9) == 0);
      drive(s, g, int'($urandom_range(1, 10)));
      checks++; if (digits !== m_digits) begin errors++; $display("FAIL rnd_digits d=%0d got %h exp %h", d, digits, m_digits); end
      checks++; if ({blank, seg_err} !== {m_blank, m_err}) begin errors++; $display("FAIL rnd_flags d=%0d got %b exp %b", d, {blank, seg_err}, {m_blank, m_err}); end
      checks++; if (sel_fault !== m_fault) begin errors++; $display("FAIL rnd_fault d=%0d got %b exp %b", d, sel_fault, m_fault); end
    end
    clr_err = 1'b0;
    checks++; if (fv_count !== m_frames) begin errors++; $display("FAIL rnd_frames got %0d exp %0d", fv_count, m_frames); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_static_scan();
    test_settling();
    test_err_blank();
    test_sel_fault();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
